div: RTL and testbench
======================

# div

Multi-cycle 32-bit signed/unsigned integer divider that produces the 64-bit {remainder, quotient} pair written into the HI/LO register file. It sits beside the EX stage: EX starts it for DIV/DIVU, holds the pipeline while it is busy, then forwards result_o to the HI/LO write port (HI = remainder, LO = quotient).

## Interface
- No parameters; data width is fixed at 32 (`RegBus).
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low (rst = 0 resets)
- signed_div_i  in  1  1 = DIV (two's-complement), 0 = DIVU
- opdata1_i  in  32  dividend
- opdata2_i  in  32  divisor
- start_i  in  1  request; held high by EX until ready_o is seen
- annul_i  in  1  cancel (flush/exception); aborts any operation in progress
- result_o  out  64  {remainder[31:0], quotient[31:0]}; valid only while ready_o = 1
- ready_o  out  1  result valid
- busy_o  out  1  high in states BYZERO and ON

## Operation
- States: FREE, BYZERO, ON, END. Register state, 6-bit cnt, 65-bit work register {rem[32:0], quo[31:0]}, latched divisor magnitude, latched sign flags.
- FREE: ready_o = 0, result_o = 0.
  - start_i = 1, annul_i = 0, opdata2_i = 0: go BYZERO.
  - start_i = 1, annul_i = 0, opdata2_i ≠ 0: latch operands and go ON with cnt = 0.
    - If signed_div_i = 1, each negative operand is replaced by its two's-complement magnitude.
    - Latch quotient-negate = sign1 XOR sign2 and remainder-negate = sign1. Both flags are 0 when unsigned.
    - Load quo = dividend magnitude and rem = 0.
  - Otherwise stay in FREE.
- BYZERO: go END with the work register cleared, so result = 0.
- ON (restoring radix-2):
  - If annul_i = 1: go FREE and discard all work.
  - Else if cnt < 32, each cycle:
    - Compute trial = {rem[31:0], quo[31]} − {1'b0, divisor}, a 33-bit subtraction.
    - If trial is non-negative: rem = trial and quo = {quo[30:0], 1}.
    - Else: rem = {rem[31:0], quo[31]} and quo = {quo[30:0], 0}.
    - cnt = cnt + 1.
  - Else (cnt = 32): apply the latched negations (quotient and remainder independently, two's complement, 32-bit wrap) and go END.
- END:
  - ready_o = 1 and result_o = {rem[31:0], quo}, both registered.
  - Stay in END while start_i = 1.
  - When start_i = 0 or annul_i = 1: go FREE and clear ready_o and result_o.
- start_i while ON or BYZERO is ignored. Operands are latched only at the FREE→ON edge, so changes during the operation have no effect.
- Arithmetic is 32-bit wrap.
  - Signed 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000 and remainder 0.
  - Remainder sign follows the dividend.

## Timing
- Reset (asynchronous, any state): state = FREE, cnt = 0, work register = 0, ready_o = 0, result_o = 0, busy_o = 0.
- Normal divide: with start sampled at edge E0, the block is in ON from E1. The 32 iterations run on edges E1..E32, the sign fix occurs on E33, and ready_o rises after E33. Total: 34 cycles from start to result, including the start cycle.
- Divide by zero: BYZERO after E0, END after E1, so ready_o is high in the 2nd cycle after the start edge.
- ready_o stays high until the first edge at which start_i = 0. It then falls on that edge.
- A new start is accepted at the earliest on the edge after ready_o falls, because FREE must be re-entered first.
- annul_i takes effect on the next edge in any state.
  - ready_o never rises for an annulled operation.
  - When annul_i and start_i are both high in FREE, annul_i wins.
- busy_o is decoded combinationally from the registered state. It carries no combinational path from any input.

## Test plan
- Unsigned 100 / 7 → ready_o rises after exactly 34 cycles; result_o = 0x00000002_0000000E. Release start_i, and ready_o drops one cycle later.
- Signed 0xFFFFFFF9 (−7) / 2 → result_o = 0xFFFFFFFF_FFFFFFFD (remainder −1, quotient −3). The same operands unsigned → 0x00000001_7FFFFFFC.
- Signed 0x80000000 / 0xFFFFFFFF → result_o = 0x00000000_80000000. Unsigned 0xFFFFFFFF / 1 → 0x00000000_FFFFFFFF.
- Divide by zero (opdata2_i = 0, either signedness) → ready_o high in cycle 2; result_o = 0. Operands that change during the operation have no effect.
- Assert annul_i 10 cycles into a divide → back in FREE with ready_o held at 0. A new 100 / 7 started 2 cycles later returns the correct result after 34 cycles.
- Drive rst low for half a cycle mid-divide (asynchronous, off the clock edge) → all outputs are 0 immediately. After release, 0xFFFFFFFF / 0x10 unsigned → 0x0000000F_0FFFFFFF.

Source files
------------

// File: rtl/div.sv
// Multi-cycle 32-bit signed/unsigned restoring divider feeding the HI/LO write port.
// result_o = {remainder, quotient}; EX holds start_i until ready_o is seen.
module div (
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o,
   output logic        busy_o
);

   typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

   state_t      state;
   logic [5:0]  cnt;
   logic [63:0] work;
   logic [31:0] divisor;
   logic        neg_quo;
   logic        neg_rem;

   logic [31:0] op1_mag;
   logic [31:0] op2_mag;
   logic [31:0] rem;
   logic [31:0] quo;
   logic [32:0] shifted;
   logic [32:0] trial;
   logic [31:0] rem_fix;
   logic [31:0] quo_fix;

   assign rem = work[63:32];
   assign quo = work[31:0];

   assign op1_mag = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
   assign op2_mag = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

   // The partial remainder never reaches the divisor, so its 33rd bit is always
   // zero after a subtraction and does not need to be stored.
   assign shifted = {rem, quo[31]};
   assign trial   = shifted - {1'b0, divisor};

   assign rem_fix = neg_rem ? (~rem + 32'd1) : rem;
   assign quo_fix = neg_quo ? (~quo + 32'd1) : quo;

   assign busy_o = (state == BYZERO) || (state == ON);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= FREE;
         cnt      <= '0;
         work     <= '0;
         divisor  <= '0;
         neg_quo  <= 1'b0;
         neg_rem  <= 1'b0;
         ready_o  <= 1'b0;
         result_o <= '0;
      end else begin
         case (state)
            FREE: begin
               ready_o  <= 1'b0;
               result_o <= '0;
               if (start_i && !annul_i) begin
                  if (opdata2_i == 32'd0) begin
                     state <= BYZERO;
                  end else begin
                     state   <= ON;
                     cnt     <= '0;
                     work    <= {32'd0, op1_mag};
                     divisor <= op2_mag;
                     neg_quo <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                     neg_rem <= signed_div_i && opdata1_i[31];
                  end
               end
            end

            BYZERO: begin
               work <= '0;
               if (annul_i) begin
                  state <= FREE;
               end else begin
                  state    <= END;
                  ready_o  <= 1'b1;
                  result_o <= '0;
               end
            end

            ON: begin
               if (annul_i) begin
                  state <= FREE;
                  cnt   <= '0;
                  work  <= '0;
               end else if (!cnt[5]) begin
                  if (!trial[32]) begin
                     work <= {trial[31:0], quo[30:0], 1'b1};
                  end else begin
                     work <= {shifted[31:0], quo[30:0], 1'b0};
                  end
                  cnt <= cnt + 6'd1;
               end else begin
                  work     <= {rem_fix, quo_fix};
                  result_o <= {rem_fix, quo_fix};
                  ready_o  <= 1'b1;
                  cnt      <= '0;
                  state    <= END;
               end
            end

            END: begin
               if (!start_i || annul_i) begin
                  state    <= FREE;
                  ready_o  <= 1'b0;
                  result_o <= '0;
               end
            end

            default: begin
               state <= FREE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div.sv
// Directed-vector bench for div: latency, signed/unsigned results, divide by zero,
// annul and asynchronous reset behaviour.
module tb_div;

   logic        clk;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;
   logic        busy_o;

   int checks = 0;
   int errors = 0;

   div dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o),
      .busy_o       (busy_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      signed_div_i = sgn;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
   endtask

   task automatic waitReady(input string tag, input int expected_cycles);
      int n;
      n = 0;
      while (!ready_o && n < 100) begin
         tick();
         n++;
      end
      checkOutput({tag, "_latency"}, 64'(n), 64'(expected_cycles));
   endtask

   task automatic runDivide(input string tag, input logic sgn, input logic [31:0] a,
                            input logic [31:0] b, input logic [63:0] expected, input int latency);
      applyStimulus(sgn, a, b);
      waitReady(tag, latency);
      checkOutput({tag, "_result"}, result_o, expected);
      start_i = 1'b0;
      tick();
      checkOutput({tag, "_ready_drop"}, {63'd0, ready_o}, 64'd0);
   endtask

   initial begin
      rst          = 1'b0;
      signed_div_i = 1'b0;
      opdata1_i    = '0;
      opdata2_i    = '0;
      start_i      = 1'b0;
      annul_i      = 1'b0;
      #12;
      checkOutput("reset_ready", {63'd0, ready_o}, 64'd0);
      checkOutput("reset_result", result_o, 64'd0);
      checkOutput("reset_busy", {63'd0, busy_o}, 64'd0);
      rst = 1'b1;
      tick();

      // Unsigned 100 / 7, result held while start stays high.
      applyStimulus(1'b0, 32'd100, 32'd7);
      waitReady("divu_100_7", 34);
      checkOutput("divu_100_7_result", result_o, 64'h00000002_0000000E);
      tick();
      checkOutput("divu_100_7_hold", {63'd0, ready_o}, 64'd1);
      start_i = 1'b0;
      tick();
      checkOutput("divu_100_7_drop", {63'd0, ready_o}, 64'd0);
      checkOutput("divu_100_7_clear", result_o, 64'd0);

      // Signed -7 / 2 with operands scrambled after the start edge.
      applyStimulus(1'b1, 32'hFFFFFFF9, 32'd2);
      tick();
      checkOutput("div_m7_2_busy", {63'd0, busy_o}, 64'd1);
      signed_div_i = 1'b0;
      opdata1_i    = 32'd5;
      opdata2_i    = 32'd0;
      waitReady("div_m7_2", 33);
      checkOutput("div_m7_2_result", result_o, 64'hFFFFFFFF_FFFFFFFD);
      start_i = 1'b0;
      tick();

      runDivide("divu_m7_2", 1'b0, 32'hFFFFFFF9, 32'd2, 64'h00000001_7FFFFFFC, 34);
      runDivide("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34);
      runDivide("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 34);

      // Signed divide by zero, divisor changed while in BYZERO.
      applyStimulus(1'b1, 32'd1234, 32'd0);
      tick();
      checkOutput("byzero_busy", {63'd0, busy_o}, 64'd1);
      checkOutput("byzero_not_ready", {63'd0, ready_o}, 64'd0);
      opdata2_i = 32'd5;
      tick();
      checkOutput("byzero_ready", {63'd0, ready_o}, 64'd1);
      checkOutput("byzero_result", result_o, 64'd0);
      start_i = 1'b0;
      tick();
      runDivide("divu_byzero", 1'b0, 32'hDEADBEEF, 32'd0, 64'd0, 2);

      // Annul ten cycles into a divide, then restart two cycles later.
      applyStimulus(1'b0, 32'd100, 32'd7);
      repeat (10) tick();
      checkOutput("annul_busy_before", {63'd0, busy_o}, 64'd1);
      annul_i = 1'b1;
      tick();
      checkOutput("annul_busy_after", {63'd0, busy_o}, 64'd0);
      checkOutput("annul_ready", {63'd0, ready_o}, 64'd0);
      annul_i = 1'b0;
      start_i = 1'b0;
      repeat (2) tick();
      checkOutput("annul_ready_later", {63'd0, ready_o}, 64'd0);
      runDivide("after_annul", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34);

      // Annul wins over start in FREE.
      annul_i = 1'b1;
      applyStimulus(1'b0, 32'd100, 32'd7);
      tick();
      checkOutput("annul_in_free_busy", {63'd0, busy_o}, 64'd0);
      annul_i = 1'b0;
      start_i = 1'b0;
      tick();

      // Asynchronous reset in the middle of a divide.
      applyStimulus(1'b0, 32'd100, 32'd7);
      repeat (5) tick();
      #2 rst = 1'b0;
      #1;
      checkOutput("async_rst_busy", {63'd0, busy_o}, 64'd0);
      checkOutput("async_rst_ready", {63'd0, ready_o}, 64'd0);
      #4 rst = 1'b1;
      start_i = 1'b0;
      repeat (2) tick();
      checkOutput("async_rst_idle", {63'd0, busy_o}, 64'd0);
      runDivide("divu_max_16", 1'b0, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF, 34);

      // Asynchronous reset while a result is being presented.
      applyStimulus(1'b0, 32'd100, 32'd7);
      waitReady("rst_in_end", 34);
      #2 rst = 1'b0;
      #1;
      checkOutput("rst_in_end_result", result_o, 64'd0);
      checkOutput("rst_in_end_ready", {63'd0, ready_o}, 64'd0);
      #4 rst = 1'b1;
      start_i = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
